// File: rtl/sipo_deframer.sv
// rtl/sipo_deframer.sv - serial-in parallel-out deframer with valid/ready output and overrun flag
//
// Rebuilds WIDTH-bit words from an MSB-first serial stream. Bits are shifted
// in on edges with bit_en, a bit counter locates word boundaries, and each
// completed word is presented on a registered valid/ready output. A word that
// completes while the previous one is still unconsumed is dropped and the
// sticky overrun flag is raised.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   sin      - serial data bit, MSB first
//   bit_en   - sin carries a valid bit this cycle
//   frame    - word-boundary marker (with bit_en: first bit of a new word;
//              without bit_en: discard the partial word)
//   ready    - consumer accepts dout this cycle
//   clr_ovr  - synchronous clear of overrun
//   dout     - assembled word
//   valid    - dout holds an unconsumed word
//   overrun  - sticky, a completed word was dropped
//   bit_cnt  - bits collected in the current partial word
module sipo_deframer #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sin,
    input  logic                     bit_en,
    input  logic                     frame,
    input  logic                     ready,
    input  logic                     clr_ovr,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     overrun,
    output logic [$clog2(WIDTH):0]   bit_cnt
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // Only the WIDTH-1 oldest bits need storing; the final bit of a word
    // comes straight from sin on the completing edge.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] word;
    logic             complete;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        complete  = 1'b0;
        word      = {shreg_q, sin};

        // Bit capture and framing
        if (bit_en) begin
            if (frame) begin
                // Restart: this bit is the MSB of a fresh word
                shreg_d    = '0;
                shreg_d[0] = sin;
                bit_cnt_d  = CW'(1);
            end else if (bit_cnt_q == LAST_BIT) begin
                complete  = 1'b1;
                shreg_d   = word[WIDTH-2:0];
                bit_cnt_d = '0;
            end else begin
                shreg_d   = word[WIDTH-2:0];
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end else if (frame) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end

        // Clear first so that a same-edge drop below wins
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end

        // Output register
        if (complete && (!valid_q || ready)) begin
            dout_d  = word;
            valid_d = 1'b1;
        end else if (complete) begin
            overrun_d = 1'b1;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_sipo_deframer.sv
// tb/tb_sipo_deframer.sv - scoreboard testbench for sipo_deframer
module tb_sipo_deframer;

    logic       clk;
    logic       rst_n;
    logic       sin;
    logic       bit_en;
    logic       frame;
    logic       ready;
    logic       clr_ovr;
    logic [3:0] dout;
    logic       valid;
    logic       overrun;
    logic [2:0] bit_cnt;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [3:0] exp_q[$];

    sipo_deframer #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sin     (sin),
        .bit_en  (bit_en),
        .frame   (frame),
        .ready   (ready),
        .clr_ovr (clr_ovr),
        .dout    (dout),
        .valid   (valid),
        .overrun (overrun),
        .bit_cnt (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor: a transfer happens on the next edge whenever valid && ready
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            tot_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got word %b expected none", dout);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (dout == e) pass_cnt++;
                else $display("FAIL sb_word: got %b expected %b at %0t", dout, e, $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic f);
        sin    = b;
        bit_en = 1'b1;
        frame  = f;
        step();
        bit_en = 1'b0;
        frame  = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w, input logic push);
        logic [3:0] t;
        t = w;
        if (push) exp_q.push_back(w);
        for (int i = 3; i >= 0; i--) send_bit(t[i], 1'b0);
    endtask

    logic [3:0] piso;
    logic [3:0] cnt_exp[4];

    initial begin
        rst_n = 1'b0; sin = 1'b0; bit_en = 1'b0; frame = 1'b0;
        ready = 1'b0; clr_ovr = 1'b0;
        #12;
        chk("rst_valid", int'(valid), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_bit_cnt", int'(bit_cnt), 0);
        rst_n = 1'b1;
        step();

        // Basic capture 1,0,1,1 with frame on first bit
        ready = 1'b1;
        exp_q.push_back(4'b1011);
        cnt_exp[0] = 4'd1; cnt_exp[1] = 4'd2; cnt_exp[2] = 4'd3; cnt_exp[3] = 4'd0;
        begin
            logic [3:0] bits;
            bits = 4'b1011;
            for (int i = 0; i < 4; i++) begin
                send_bit(bits[3-i], i == 0);
                chk("basic_bit_cnt", int'(bit_cnt), int'(cnt_exp[i]));
                if (i < 3) chk("basic_valid_low", int'(valid), 0);
            end
        end
        chk("basic_valid", int'(valid), 1);
        chk("basic_dout", int'(dout), 4'b1011);
        step();
        chk("basic_valid_one_cycle", int'(valid), 0);

        // End-to-end with a PISO model loaded with 0110, consumer stalled
        ready = 1'b0;
        piso = 4'b0110;
        exp_q.push_back(4'b0110);
        for (int i = 0; i < 4; i++) begin
            send_bit(piso[3], 1'b0);
            piso = {piso[2:0], 1'b0};
        end
        step(); step(); step();
        chk("piso_valid_held", int'(valid), 1);
        chk("piso_dout", int'(dout), 4'b0110);
        ready = 1'b1;
        step();
        chk("piso_valid_drop", int'(valid), 0);

        // Stall and overrun: 1100 kept, 0011 dropped
        ready = 1'b0;
        send_word(4'b1100, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("ovr_before_8th", int'(overrun), 0);
        clr_ovr = 1'b1;               // set must win over same-edge clear
        send_bit(1'b1, 1'b0);
        clr_ovr = 1'b0;
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_dout_kept", int'(dout), 4'b1100);
        chk("ovr_valid_kept", int'(valid), 1);
        chk("ovr_bit_cnt", int'(bit_cnt), 0);
        ready = 1'b1;
        step();
        chk("ovr_valid_drop", int'(valid), 0);
        chk("ovr_sticky", int'(overrun), 1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);

        // Simultaneous accept and complete
        ready = 1'b0;
        send_word(4'b1111, 1'b1);
        exp_q.push_back(4'b1001);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("sim_hold_dout", int'(dout), 4'b1111);
        ready = 1'b1;
        send_bit(1'b1, 1'b0);
        chk("sim_dout", int'(dout), 4'b1001);
        chk("sim_valid", int'(valid), 1);
        chk("sim_overrun", int'(overrun), 0);
        step();

        // Resync with frame + bit_en
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("resync_partial_cnt", int'(bit_cnt), 2);
        exp_q.push_back(4'b0101);
        send_bit(1'b0, 1'b1);
        chk("resync_cnt_1", int'(bit_cnt), 1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("resync_dout", int'(dout), 4'b0101);
        chk("resync_valid", int'(valid), 1);
        step();

        // Resync with frame alone
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        frame = 1'b1;
        step();
        frame = 1'b0;
        chk("frame_only_cnt", int'(bit_cnt), 0);
        send_word(4'b0110, 1'b1);
        chk("frame_only_dout", int'(dout), 4'b0110);
        step();

        // Async reset mid-word with valid and overrun set
        ready = 1'b0;
        send_word(4'b1010, 1'b1);
        send_word(4'b0101, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("prerst_overrun", int'(overrun), 1);
        chk("prerst_valid", int'(valid), 1);
        chk("prerst_cnt", int'(bit_cnt), 2);
        #2 rst_n = 1'b0;
        #2;
        chk("arst_valid", int'(valid), 0);
        chk("arst_dout", int'(dout), 0);
        chk("arst_overrun", int'(overrun), 0);
        chk("arst_bit_cnt", int'(bit_cnt), 0);
        exp_q.delete();
        #1 rst_n = 1'b1;
        ready = 1'b1;
        exp_q.push_back(4'b1101);
        send_word(4'b1101, 1'b0);
        chk("postrst_valid", int'(valid), 1);
        chk("postrst_dout", int'(dout), 4'b1101);
        step();
        step();

        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
